// File: rtl/control_sequencer_if.sv
// control_sequencer_if: control bundle between the hardwired sequencer and the single-bus datapath
interface control_sequencer_if #(parameter int OP_WIDTH = 5, parameter int IR_WIDTH = 32);
   logic [IR_WIDTH-1:0] IR;
   logic CON_FF, mem_done, stop, run, illegal;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
   logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin;
   logic Gra, Grb, Grc, Rin, Rout, BAout, link_sel;
   logic [OP_WIDTH-1:0] alu_op;
   modport master (
      input IR, CON_FF, mem_done, stop,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
      output Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin,
      output Gra, Grb, Grc, Rin, Rout, BAout, link_sel, alu_op, run, illegal
   );
   modport slave (
      output IR, CON_FF, mem_done, stop,
      input PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
      input Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin,
      input Gra, Grb, Grc, Rin, Rout, BAout, link_sel, alu_op, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0-T7 control unit for the single-bus RISC datapath.
// Define ILLEGAL_TRAP_EN to trap opcodes 11011-11111 into HALT with illegal=1; otherwise they act as nop.
module control_sequencer #(parameter int OP_WIDTH = 5, parameter int IR_WIDTH = 32) (
   input logic clk,
   input logic clr,
   control_sequencer_if.master cs
);
   typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
   localparam logic [OP_WIDTH-1:0] ADD = OP_WIDTH'(3);
   state_t state_q, state_d;
   logic stop_q, stop_d, illegal_q, illegal_d, last;
   logic [OP_WIDTH-1:0] op;
   logic ld, ldi, st, mem_cls, alu_r, alu_i, muldiv, negnot, br, jr, jal, halt;
   assign op = cs.IR[IR_WIDTH-1 -: OP_WIDTH];
   assign ld = op == 5'd0;
   assign ldi = op == 5'd1;
   assign st = op == 5'd2;
   assign mem_cls = ld | ldi | st;
   assign alu_r = op inside {[5'd3:5'd10]};
   assign alu_i = op inside {[5'd11:5'd13]};
   assign muldiv = op inside {5'd14, 5'd15};
   assign negnot = op inside {5'd16, 5'd17};
   assign br = op == 5'd18;
   assign jr = op == 5'd19;
   assign jal = op == 5'd20;
   assign halt = op == 5'd26;
`ifdef ILLEGAL_TRAP_EN
   logic ill;
   assign ill = op inside {[5'd27:5'd31]};
`endif
   assign cs.run = clr | (state_q != HALT);
   assign cs.illegal = illegal_q;
   always_comb begin
      {cs.PCout, cs.PCin, cs.IncPC, cs.MARin, cs.MDRin, cs.MDRout, cs.Read, cs.Write, cs.IRin,
       cs.Yin, cs.Zin, cs.Zhighout, cs.Zlowout, cs.HIin, cs.LOin, cs.HIout, cs.LOout, cs.Cout,
       cs.CONin, cs.InPortout, cs.OutPortin, cs.Gra, cs.Grb, cs.Grc, cs.Rin, cs.Rout, cs.BAout,
       cs.link_sel} = '0;
      cs.alu_op = '0;
      state_d = state_q;
      illegal_d = illegal_q;
      last = 1'b0;
      if (!clr)
         case (state_q)
            T0: begin
               {cs.PCout, cs.MARin, cs.IncPC, cs.Zin} = '1;
               state_d = T1;
            end
            T1: begin
               {cs.Zlowout, cs.PCin, cs.Read, cs.MDRin} = '1;
               if (cs.mem_done) state_d = T2;
            end
            T2: begin
               {cs.MDRout, cs.IRin} = '1;
               state_d = T3;
            end
            HALT: ;
            default: begin
               state_d = state_t'(state_q + 4'd1);
               // ldi, ld and st share the base-plus-offset address add in T3-T5
               if (mem_cls)
                  case (state_q)
                     T3: {cs.Grb, cs.BAout, cs.Yin} = '1;
                     T4: begin {cs.Cout, cs.Zin} = '1; cs.alu_op = ADD; end
                     T5: begin cs.Zlowout = 1'b1; cs.Gra = ldi; cs.Rin = ldi; cs.MARin = !ldi; last = ldi; end
                     T6: begin
                        cs.MDRin = 1'b1; cs.Read = ld; cs.Gra = st; cs.Rout = st;
                        if (ld && !cs.mem_done) state_d = T6;
                     end
                     default: begin
                        cs.MDRout = ld; cs.Gra = ld; cs.Rin = ld; cs.Write = st;
                        last = ld | cs.mem_done;
                        if (!last) state_d = T7;
                     end
                  endcase
               else if (alu_r | alu_i)
                  case (state_q)
                     T3: {cs.Grb, cs.Rout, cs.Yin} = '1;
                     T4: begin cs.Grc = alu_r; cs.Rout = alu_r; cs.Cout = alu_i; cs.Zin = 1'b1; cs.alu_op = op; end
                     default: begin {cs.Zlowout, cs.Gra, cs.Rin} = '1; last = 1'b1; end
                  endcase
               else if (muldiv)
                  case (state_q)
                     T3: {cs.Gra, cs.Rout, cs.Yin} = '1;
                     T4: begin {cs.Grb, cs.Rout, cs.Zin} = '1; cs.alu_op = op; end
                     T5: {cs.Zlowout, cs.LOin} = '1;
                     default: begin {cs.Zhighout, cs.HIin} = '1; last = 1'b1; end
                  endcase
               else if (negnot) begin
                  if (state_q == T3) begin {cs.Grb, cs.Rout, cs.Zin} = '1; cs.alu_op = op; end
                  else begin {cs.Zlowout, cs.Gra, cs.Rin} = '1; last = 1'b1; end
               end
               else if (br)
                  case (state_q)
                     T3: {cs.Gra, cs.Rout, cs.CONin} = '1;
                     T4: {cs.PCout, cs.Yin} = '1;
                     T5: begin {cs.Cout, cs.Zin} = '1; cs.alu_op = ADD; end
                     default: begin cs.Zlowout = cs.CON_FF; cs.PCin = cs.CON_FF; last = 1'b1; end
                  endcase
               else if (jal && state_q == T3) {cs.PCout, cs.Rin, cs.link_sel} = '1;
               else if (jal | jr) begin {cs.Gra, cs.Rout, cs.PCin} = '1; last = 1'b1; end
               else if (halt) state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
               else if (ill) begin illegal_d = 1'b1; state_d = HALT; end
`endif
               else begin
                  cs.InPortout = op == 5'd21;
                  cs.OutPortin = op == 5'd22;
                  cs.HIout = op == 5'd23;
                  cs.LOout = op == 5'd24;
                  cs.Gra = op inside {[5'd21:5'd24]};
                  cs.Rin = op inside {5'd21, 5'd23, 5'd24};
                  cs.Rout = op == 5'd22;
                  last = 1'b1;
               end
            end
         endcase
      // a stop seen mid-instruction is held until the instruction's final step
      stop_d = !last & (stop_q | cs.stop);
      if (last) state_d = (stop_q | cs.stop) ? HALT : T0;
   end
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         state_q <= T0;
         stop_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q <= stop_d;
         illegal_q <= illegal_d;
      end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer; honours ILLEGAL_TRAP_EN if defined.
module tb_control_sequencer;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;
   control_sequencer_if #(.OP_WIDTH(5), .IR_WIDTH(32)) cs ();
   control_sequencer dut (.clk(clk), .clr(clr), .cs(cs));
   localparam logic [27:0] PCOUT = 28'd1 << 27, PCIN = 28'd1 << 26, INCPC = 28'd1 << 25, MARIN = 28'd1 << 24;
   localparam logic [27:0] MDRIN = 28'd1 << 23, MDROUT = 28'd1 << 22, READ = 28'd1 << 21, WRITE = 28'd1 << 20;
   localparam logic [27:0] IRIN = 28'd1 << 19, YIN = 28'd1 << 18, ZIN = 28'd1 << 17, ZHI = 28'd1 << 16;
   localparam logic [27:0] ZLO = 28'd1 << 15, HIIN = 28'd1 << 14, LOIN = 28'd1 << 13, HIOUT = 28'd1 << 12;
   localparam logic [27:0] LOOUT = 28'd1 << 11, COUT = 28'd1 << 10, CONIN = 28'd1 << 9, INP = 28'd1 << 8;
   localparam logic [27:0] OUTP = 28'd1 << 7, GRA = 28'd1 << 6, GRB = 28'd1 << 5, GRC = 28'd1 << 4;
   localparam logic [27:0] RIN = 28'd1 << 3, ROUT = 28'd1 << 2, BAOUT = 28'd1 << 1, LINK = 28'd1;
   localparam logic [27:0] F0 = PCOUT | MARIN | INCPC | ZIN, F1 = ZLO | PCIN | READ | MDRIN, F2 = MDROUT | IRIN;
   logic [27:0] strb;
   assign strb = {cs.PCout, cs.PCin, cs.IncPC, cs.MARin, cs.MDRin, cs.MDRout, cs.Read, cs.Write, cs.IRin,
                  cs.Yin, cs.Zin, cs.Zhighout, cs.Zlowout, cs.HIin, cs.LOin, cs.HIout, cs.LOout, cs.Cout,
                  cs.CONin, cs.InPortout, cs.OutPortin, cs.Gra, cs.Grb, cs.Grc, cs.Rin, cs.Rout, cs.BAout,
                  cs.link_sel};
   int n_cmp = 0;
   int n_bad = 0;

   task automatic test_reset();
      cs.IR = {5'b00011, 27'h0123456};
      #1;
      n_cmp++; if (strb !== 28'd0) begin n_bad++; $display("FAIL reset strobes got %h want 0", strb); end
      n_cmp++; if (cs.alu_op !== 5'd0) begin n_bad++; $display("FAIL reset alu_op got %h want 0", cs.alu_op); end
      n_cmp++; if (cs.run !== 1'b1) begin n_bad++; $display("FAIL reset run got %b want 1", cs.run); end
      n_cmp++; if (cs.illegal !== 1'b0) begin n_bad++; $display("FAIL reset illegal got %b want 0", cs.illegal); end
      clr = 1'b0;
      #1;
      n_cmp++; if (strb !== F0) begin n_bad++; $display("FAIL reset_release strobes got %h want %h", strb, F0); end
   endtask

   task automatic test_add();
      logic [27:0] e [7];
      logic [4:0] ea;
      e = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLO | GRA | RIN, F0};
      cs.IR = {5'b00011, 27'h0123456};
      cs.mem_done = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
         ea = (i == 4) ? 5'b00011 : 5'd0;
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL add[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.alu_op !== ea) begin n_bad++; $display("FAIL add[%0d] alu_op got %h want %h", i, cs.alu_op, ea); end
         if (i < 6) begin @(negedge clk); #1; end
      end
   endtask

   task automatic test_ld_wait();
      logic [27:0] e [12];
      logic md [12];
      logic [4:0] ea;
      e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN, ZLO | MARIN, READ | MDRIN, READ | MDRIN,
            READ | MDRIN, READ | MDRIN, MDROUT | GRA | RIN, F0};
      md = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
      cs.IR = {5'b00000, 27'h0456789};
      #1;
      for (int i = 0; i < 12; i++) begin
         cs.mem_done = md[i];
         ea = (i == 4) ? 5'b00011 : 5'd0;
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL ld[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.alu_op !== ea) begin n_bad++; $display("FAIL ld[%0d] alu_op got %h want %h", i, cs.alu_op, ea); end
         if (i < 11) begin @(negedge clk); #1; end
      end
   endtask

   task automatic test_st_write();
      logic [27:0] e [10];
      logic md [10];
      e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN, ZLO | MARIN, GRA | ROUT | MDRIN, WRITE, WRITE, F0};
      md = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
      cs.IR = {5'b00010, 27'h0111111};
      #1;
      for (int i = 0; i < 10; i++) begin
         cs.mem_done = md[i];
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL st[%0d] strobes got %h want %h", i, strb, e[i]); end
         if (i < 9) begin @(negedge clk); #1; end
      end
   endtask

   task automatic test_br();
      logic [27:0] e [8];
      logic [4:0] ea;
      cs.IR = {5'b10010, 27'h0222222};
      cs.mem_done = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cs.CON_FF = c[0];
         e = '{F0, F1, F2, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN, c[0] ? (ZLO | PCIN) : 28'd0, F0};
         #1;
         for (int i = 0; i < 8; i++) begin
            ea = (i == 5) ? 5'b00011 : 5'd0;
            n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL br%0d[%0d] strobes got %h want %h", c, i, strb, e[i]); end
            n_cmp++; if (cs.alu_op !== ea) begin n_bad++; $display("FAIL br%0d[%0d] alu_op got %h want %h", c, i, cs.alu_op, ea); end
            if (i < 7) begin @(negedge clk); #1; end
         end
      end
      cs.CON_FF = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [27:0] e [18];
      logic [4:0] ops [18];
      logic [4:0] ea;
      e = '{F0, F1, F2, GRA | ROUT | YIN, GRB | ROUT | ZIN, ZLO | LOIN, ZHI | HIIN,
            F0, F1, F2, PCOUT | RIN | LINK, GRA | ROUT | PCIN,
            F0, F1, F2, GRB | ROUT | ZIN, ZLO | GRA | RIN, F0};
      ops = '{5'b01110, 5'b01110, 5'b01110, 5'b01110, 5'b01110, 5'b01110, 5'b01110,
              5'b10100, 5'b10100, 5'b10100, 5'b10100, 5'b10100,
              5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11001};
      for (int i = 0; i < 18; i++) begin
         cs.IR = {ops[i], 27'h0333333};
         #1;
         ea = (i == 4) ? 5'b01110 : (i == 15) ? 5'b10000 : 5'd0;
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL b2b[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.alu_op !== ea) begin n_bad++; $display("FAIL b2b[%0d] alu_op got %h want %h", i, cs.alu_op, ea); end
         if (i < 17) @(negedge clk);
      end
   endtask

   task automatic test_halt();
      logic [27:0] e [5];
      logic r [5];
      e = '{F0, F1, F2, 28'd0, 28'd0};
      r = '{1, 1, 1, 1, 0};
      cs.IR = {5'b11010, 27'h0444444};
      #1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL halt[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.run !== r[i]) begin n_bad++; $display("FAIL halt[%0d] run got %b want %b", i, cs.run, r[i]); end
         if (i < 4) begin @(negedge clk); #1; end
      end
      clr = 1'b1;
      #1;
      clr = 1'b0;
      #1;
      n_cmp++; if (strb !== F0) begin n_bad++; $display("FAIL halt_clr strobes got %h want %h", strb, F0); end
   endtask

   task automatic test_stop();
      logic [27:0] e [8];
      logic r [8];
      e = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLO | GRA | RIN, 28'd0, 28'd0};
      r = '{1, 1, 1, 1, 1, 1, 0, 0};
      cs.IR = {5'b00100, 27'h0555555};
      #1;
      for (int i = 0; i < 8; i++) begin
         cs.stop = (i == 1);
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL stop[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.run !== r[i]) begin n_bad++; $display("FAIL stop[%0d] run got %b want %b", i, cs.run, r[i]); end
         if (i < 7) begin @(negedge clk); #1; end
      end
      clr = 1'b1;
      #1;
      n_cmp++; if (cs.run !== 1'b1) begin n_bad++; $display("FAIL stop_clr run got %b want 1", cs.run); end
      clr = 1'b0;
      #1;
      n_cmp++; if (strb !== F0) begin n_bad++; $display("FAIL stop_clr strobes got %h want %h", strb, F0); end
   endtask

   task automatic test_clr_mid_st();
      logic [27:0] e [7];
      e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN, ZLO | MARIN, GRA | ROUT | MDRIN};
      cs.IR = {5'b00010, 27'h0666666};
      cs.mem_done = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL clr_st[%0d] strobes got %h want %h", i, strb, e[i]); end
         if (i < 6) begin @(negedge clk); #1; end
      end
      clr = 1'b1;
      #1;
      n_cmp++; if (strb !== 28'd0) begin n_bad++; $display("FAIL clr_st_same strobes got %h want 0", strb); end
      @(negedge clk);
      #1;
      n_cmp++; if (cs.Write !== 1'b0) begin n_bad++; $display("FAIL clr_st_write got %b want 0", cs.Write); end
      clr = 1'b0;
      #1;
      n_cmp++; if (strb !== F0) begin n_bad++; $display("FAIL clr_st_release strobes got %h want %h", strb, F0); end
   endtask

   task automatic test_illegal();
      logic [27:0] e [5];
      logic r [5];
      logic il [5];
`ifdef ILLEGAL_TRAP_EN
      e = '{F0, F1, F2, 28'd0, 28'd0};
      r = '{1, 1, 1, 1, 0};
      il = '{0, 0, 0, 0, 1};
`else
      e = '{F0, F1, F2, 28'd0, F0};
      r = '{1, 1, 1, 1, 1};
      il = '{0, 0, 0, 0, 0};
`endif
      cs.IR = {5'b11111, 27'h0777777};
      #1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (strb !== e[i]) begin n_bad++; $display("FAIL illegal[%0d] strobes got %h want %h", i, strb, e[i]); end
         n_cmp++; if (cs.run !== r[i]) begin n_bad++; $display("FAIL illegal[%0d] run got %b want %b", i, cs.run, r[i]); end
         n_cmp++; if (cs.illegal !== il[i]) begin n_bad++; $display("FAIL illegal[%0d] flag got %b want %b", i, cs.illegal, il[i]); end
         if (i < 4) begin @(negedge clk); #1; end
      end
      clr = 1'b1;
      #1;
      n_cmp++; if (cs.illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_clr flag got %b want 0", cs.illegal); end
      clr = 1'b0;
      #1;
   endtask

   initial begin
      cs.IR = '0;
      cs.CON_FF = 1'b0;
      cs.mem_done = 1'b0;
      cs.stop = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      test_reset();
      test_add();
      test_ld_wait();
      test_st_write();
      test_br();
      test_back_to_back();
      test_halt();
      test_stop();
      test_clr_mid_st();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus RISC datapath.
- Steps each instruction through fetch (T0–T2) and class-specific execute steps (T3–T7).
- Drives every register-enable, bus-output, memory and select-encode strobe, including Gra/Grb/Grc/Rin/Rout/BAout into the IR select/encode logic.
- Waits on a memory done handshake and halts on a halt opcode or the external stop input.

Parameters:
- OP_WIDTH, 5, opcode width; opcode is IR[31:27].
- IR_WIDTH, 32, instruction register width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- IR  in  IR_WIDTH  instruction register contents.
- CON_FF  in  1  branch condition result.
- mem_done  in  1  memory access complete this cycle.
- stop  in  1  request halt at the next instruction boundary.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin  out  1 each  fetch/memory strobes.
- Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, link_sel  out  1 each  register select/encode controls; link_sel forces R15.
- alu_op  out  OP_WIDTH  ALU operation; ADD code 00011 for address and branch-target adds.
- run  out  1  high while executing, low in HALT.
- illegal  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- State register: T0..T7, HALT.
- All strobes are combinational decode of the state register and IR[31:27].
- While clr is high: state is T0, every strobe is 0, alu_op is 0, run is 1, illegal is 0. clr mid-instruction abandons it immediately.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin; remain in T1 until mem_done=1.
  - T2: MDRout, IRin.
- Execute, by opcode:
  - ALU-R, 00011–01010: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=op; T5 Zlowout Gra Rin.
  - ALU-I, 01011–01101: T3 Grb Rout Yin; T4 Cout Zin alu_op=op; T5 Zlowout Gra Rin.
  - ldi, 00001: T3 Grb BAout Yin; T4 Cout Zin ADD; T5 Zlowout Gra Rin.
  - ld, 00000: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin, hold until mem_done; T7 MDRout Gra Rin.
  - st, 00010: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write, hold until mem_done.
  - mul/div, 01110/01111: T3 Gra Rout Yin; T4 Grb Rout Zin alu_op=op; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not, 10000/10001: T3 Grb Rout Zin alu_op=op; T4 Zlowout Gra Rin.
  - br, 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin ADD; T6 Zlowout PCin only if CON_FF=1, otherwise no strobes.
  - jr, 10011: T3 Gra Rout PCin.
  - jal, 10100: T3 PCout Rin link_sel; T4 Gra Rout PCin.
  - in, 10101: T3 InPortout Gra Rin.
  - out, 10110: T3 Gra Rout OutPortin.
  - mfhi, 10111: T3 HIout Gra Rin.
  - mflo, 11000: T3 LOout Gra Rin.
  - nop, 11001: T3 no strobes.
  - halt, 11010: T3 → HALT.
  - Opcodes 11011–11111: illegal.
- After an instruction's last step the next state is T0, or HALT if stop=1 in that cycle.
- stop asserted during T0–T2 takes effect at the end of the current instruction; no partial instruction.
- HALT: all strobes 0, run=0; exited only by clr.
- mem_done is ignored outside T1, T6 (ld) and T7 (st).
- mem_done may stay low indefinitely; strobes stay asserted throughout the wait.
- Fetch-to-fetch latency with zero wait: ALU-R 6 cycles, ld/st 8 cycles.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: illegal opcode at T3 sets illegal=1 (held until clr), no strobes, next state HALT.
- Undefined: illegal opcodes behave as nop; illegal tied to 0.

Test Plan:
- clr pulse, then opcode 00011 (add) with mem_done always 1 → T0..T5 strobes exactly as specified, alu_op=00011 at T4 only, back in T0 on cycle 7.
- ld with mem_done low 3 cycles in T6 → Read and MDRin held 4 cycles, MDRout Gra Rin in T7, total 11 cycles.
- br with CON_FF=0, then repeated with CON_FF=1 → PCin asserted in T6 only in the second run.
- stop raised during T1 of an add → add completes, state HALT, run=0; clr returns run=1 in T0.
- clr asserted during T6 of st → all strobes 0 in the same cycle, no Write issued.
- opcode 11111 → with ILLEGAL_TRAP_EN: illegal=1 and HALT after T3; without it: T3 idle then T0.
